// File: rtl/morse_pkg.sv
// Shared Signals codes, FSM state encoding and letter limits for morse_key_classifier.
package morse_pkg;

    localparam logic [2:0] SIG_DOT    = 3'b000;
    localparam logic [2:0] SIG_DASH   = 3'b001;
    localparam logic [2:0] SIG_SPACE  = 3'b010;
    localparam logic [2:0] SIG_ENDSEQ = 3'b011;
    localparam logic [2:0] SIG_IDLE   = 3'b111;

    // Downstream buffer holds 10 bits, i.e. five 2-bit symbols per letter.
    localparam int unsigned MAX_SYMBOLS = 5;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        LGAP,
        HOLD
    } state_t;

endpackage

// File: rtl/morse_key_classifier_key_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for the raw Morse key.
// key_idle reports a released key only once the synchroniser holds post-reset samples.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db,
    output logic key_idle
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [1:0]    primed;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            primed <= '0;
            db_cnt <= '0;
            key_db <= 1'b0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
            primed <= {primed[0], 1'b1};
            if (sync_2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_idle = primed[1] & ~sync_2;

endmodule

// File: rtl/morse_key_classifier.sv
// Morse key classifier: debounced key -> dot/dash/space/endseq strobes on Signals/Valid.
// Optional sidetone divider on Tone when MORSE_SIDETONE_EN is defined.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned UNIT_CYCLES      = 1000,
    parameter int unsigned DASH_UNITS       = 2,
    parameter int unsigned LETTER_GAP_UNITS = 3,
    parameter int unsigned WORD_GAP_UNITS   = 7,
    parameter int unsigned CNT_W            = 24
`ifdef MORSE_SIDETONE_EN
    ,
    parameter int unsigned TONE_DIV         = 500
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Key,
    input  logic       Clear,
    output logic [2:0] Signals,
    output logic       Valid,
    output logic       Overflow,
    output logic       Tone
);

    localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);
    localparam logic [2:0]       SYM_MAX   = 3'(MAX_SYMBOLS);

    logic             key_db;
    logic             key_idle;
    logic             armed;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, elapsed;
    logic [2:0]       sym_cnt, sym_n;
    logic             ovf_n;
    logic [2:0]       sig_n;
    logic             val_n;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (Clock),
        .rst     (Reset),
        .key_raw (Key),
        .key_db  (key_db),
        .key_idle(key_idle)
    );

    // A key held through reset must be released once before a press counts.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sym_cnt  <= '0;
            armed    <= 1'b0;
            Overflow <= 1'b0;
            Signals  <= SIG_IDLE;
            Valid    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sym_cnt  <= sym_n;
            armed    <= armed | key_idle;
            Overflow <= ovf_n;
            Signals  <= sig_n;
            Valid    <= val_n;
        end
    end

    // Durations are judged on the value the counter would take this cycle,
    // so a press seen high for N cycles measures exactly N.
    always_comb begin
        elapsed = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sym_n   = sym_cnt;
        ovf_n   = Overflow;
        sig_n   = SIG_IDLE;
        val_n   = 1'b0;

        if (Clear) begin
            state_n = key_db ? HOLD : IDLE;
            cnt_n   = '0;
            sym_n   = '0;
            ovf_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_db) begin
                        state_n = armed ? PRESS : HOLD;
                        cnt_n   = '0;
                    end
                end
                PRESS: begin
                    if (key_db) begin
                        cnt_n = elapsed;
                    end else begin
                        state_n = GAP;
                        cnt_n   = '0;
                        if (sym_cnt < SYM_MAX) begin
                            sig_n = (elapsed >= DASH_TH) ? SIG_DASH : SIG_DOT;
                            val_n = 1'b1;
                            sym_n = sym_cnt + 3'd1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (key_db) begin
                        state_n = PRESS;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = elapsed;
                        if (elapsed == LETTER_TH) begin
                            state_n = LGAP;
                            sig_n   = SIG_SPACE;
                            val_n   = 1'b1;
                            sym_n   = '0;
                            ovf_n   = 1'b0;
                        end
                    end
                end
                LGAP: begin
                    if (key_db) begin
                        state_n = PRESS;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = elapsed;
                        if (elapsed == WORD_TH) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            sig_n   = SIG_ENDSEQ;
                            val_n   = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!key_db) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef MORSE_SIDETONE_EN
    localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    logic [TW-1:0] tone_cnt;
    logic          tone_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (!key_db) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign Tone = tone_q;
`else
    assign Tone = 1'b0;
`endif

endmodule
